multicycle_ctrl: RTL and testbench

Multicycle control sequencer that sits directly upstream of the 4x8-bit register file and drives its c4..c10 control lines. It fetches 8-bit instructions (and an optional immediate byte) from program memory over a req/ready handshake, then decodes them. It steps a Moore FSM that selects read ports, ALU operation, the A_in source and the single-cycle write enable.

---
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle fetch/decode sequencer driving register-file controls c4..c10
module multicycle_ctrl #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mem_data,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       c8,
  output logic       c9,
  output logic       c10,
  output logic [2:0] alu_op,
  output logic       src_sel,
  output logic [7:0] imm,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  state_t     state_next;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       is_alu;
  logic [2:0] alu_dec;

  assign opcode = ir[7:4];
  assign rd     = ir[3:2];
  assign rs     = ir[1:0];

  // Opcode decode: which instructions use the ALU path and their function code
  always_comb begin
    is_alu  = 1'b0;
    alu_dec = 3'b000;
    case (opcode)
      OP_MOV: begin is_alu = 1'b1; alu_dec = 3'b000; end
      OP_ADD: begin is_alu = 1'b1; alu_dec = 3'b001; end
      OP_SUB: begin is_alu = 1'b1; alu_dec = 3'b010; end
      OP_AND: begin is_alu = 1'b1; alu_dec = 3'b011; end
      OP_OR:  begin is_alu = 1'b1; alu_dec = 3'b100; end
      OP_XOR: begin is_alu = 1'b1; alu_dec = 3'b101; end
      OP_NOT: begin is_alu = 1'b1; alu_dec = 3'b110; end
      default: begin is_alu = 1'b0; alu_dec = 3'b000; end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch datapath: instruction, immediate and pc only move on an accepted fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= PC_RESET;
      ir  <= 8'h00;
      imm <= 8'h00;
    end else if (mem_ready && state == S_FETCH) begin
      ir <= mem_data;
      pc <= pc + 8'd1;
    end else if (mem_ready && state == S_FETCH_IMM) begin
      imm <= mem_data;
      pc  <= pc + 8'd1;
    end
  end

  assign mem_addr = pc;

  // Next-state and Moore control outputs, decoded from registered state only
  always_comb begin
    state_next       = state;
    mem_req          = 1'b0;
    {c4, c5}         = 2'b00;
    {c6, c7}         = 2'b00;
    {c8, c9}         = 2'b00;
    c10              = 1'b0;
    alu_op           = 3'b000;
    src_sel          = 1'b0;
    halted           = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        {c4, c5} = rd;
        {c6, c7} = rs;
        {c8, c9} = rd;
        if (opcode == OP_LDI)       state_next = S_FETCH_IMM;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else if (is_alu)            state_next = S_EXEC;
        else                        state_next = S_FETCH;
      end
      S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_WB;
      end
      S_EXEC: begin
        {c4, c5}   = rd;
        {c6, c7}   = rs;
        {c8, c9}   = rd;
        alu_op     = alu_dec;
        state_next = S_WB;
      end
      S_WB: begin
        {c4, c5}   = rd;
        {c6, c7}   = rs;
        {c8, c9}   = rd;
        alu_op     = alu_dec;
        c10        = 1'b1;
        src_sel    = (opcode == OP_LDI);
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // NOP is handled by the default decode path; named here so the opcode map stays complete
  logic unused_nop;
  assign unused_nop = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clock;
  logic       reset_n;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       c4, c5, c6, c7, c8, c9, c10;
  logic [2:0] alu_op;
  logic       src_sel;
  logic [7:0] imm;
  logic       halted;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .c4       (c4),
    .c5       (c5),
    .c6       (c6),
    .c7       (c7),
    .c8       (c8),
    .c9       (c9),
    .c10      (c10),
    .alu_op   (alu_op),
    .src_sel  (src_sel),
    .imm      (imm),
    .halted   (halted)
  );

  assign mem_data = mem[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h84;
    mem[1] = 8'h5A;
    mem[2] = 8'h2B;
    mem[3] = 8'h1D;
    mem[4] = 8'h00;
    mem[5] = 8'hF0;
  endtask

  int  c10_seen;
  bit  found;

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    load_prog();
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_c10", c10, 0);
    check("rst_ctrl", {c4, c5, c6, c7, c8, c9, alu_op, src_sel, halted}, 0);
    check("rst_imm", imm, 0);

    // Test 1: LDI R1, 0x5A
    reset_n = 1'b1;
    check("idle_req", mem_req, 0);
    step();
    check("t1_fetch_req", mem_req, 1);
    check("t1_fetch_addr", mem_addr, 8'h00);
    step();
    check("t1_dec_rd", {c4, c5}, 2'b01);
    check("t1_dec_c10", c10, 0);
    check("t1_dec_req", mem_req, 0);
    step();
    check("t1_fimm_req", mem_req, 1);
    check("t1_fimm_addr", mem_addr, 8'h01);
    step();
    check("t1_wb_c10", c10, 1);
    check("t1_wb_wsel", {c8, c9}, 2'b01);
    check("t1_wb_src", src_sel, 1);
    check("t1_wb_imm", imm, 8'h5A);
    check("t1_wb_pc", mem_addr, 8'h02);
    check("t1_wb_alu", alu_op, 3'b000);

    // Test 2: ADD R2,R3
    step();
    check("t2_fetch_c10", c10, 0);
    check("t2_fetch_addr", mem_addr, 8'h02);
    step();
    check("t2_dec_r1", {c4, c5}, 2'b10);
    check("t2_dec_r2", {c6, c7}, 2'b11);
    check("t2_dec_alu", alu_op, 3'b000);
    check("t2_dec_c10", c10, 0);
    step();
    check("t2_ex_r1", {c4, c5}, 2'b10);
    check("t2_ex_r2", {c6, c7}, 2'b11);
    check("t2_ex_alu", alu_op, 3'b001);
    check("t2_ex_c10", c10, 0);
    mem_ready = 1'b0;
    step();
    check("t2_wb_c10", c10, 1);
    check("t2_wb_wsel", {c8, c9}, 2'b10);
    check("t2_wb_src", src_sel, 0);
    check("t2_wb_alu", alu_op, 3'b001);
    check("t2_wb_r2", {c6, c7}, 2'b11);
    check("t2_wb_imm_hold", imm, 8'h5A);

    // Test 3: fetch stall of three cycles, then MOV R3,R1
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall_req", mem_req, 1);
      check("t3_stall_addr", mem_addr, 8'h03);
      check("t3_stall_c10", c10, 0);
    end
    mem_ready = 1'b1;
    step();
    check("t3_dec_pc", mem_addr, 8'h04);
    check("t3_dec_req", mem_req, 0);
    check("t3_dec_r1", {c4, c5}, 2'b11);
    check("t3_dec_r2", {c6, c7}, 2'b01);
    step();
    check("t3_ex_alu", alu_op, 3'b000);
    step();
    check("t3_wb_c10", c10, 1);
    check("t3_wb_wsel", {c8, c9}, 2'b11);

    // NOP at 4 takes two cycles, no write
    step();
    check("nop_fetch_addr", mem_addr, 8'h04);
    step();
    check("nop_dec_c10", c10, 0);
    step();
    check("nop_next_fetch", {mem_req, mem_addr}, {1'b1, 8'h05});

    // Test 4: HALT is sticky
    step();
    for (int i = 0; i < 22; i++) begin
      step();
      check("t4_halted", halted, 1);
      check("t4_req", mem_req, 0);
      check("t4_c10", c10, 0);
    end
    check("t4_pc", mem_addr, 8'h06);
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_halted", halted, 0);
    check("t4_rst_pc", mem_addr, 8'h00);
    step();
    reset_n = 1'b1;

    // Test 5: reset during WB of LDI
    step();
    step();
    step();
    step();
    check("t5_wb_c10", c10, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_c10", c10, 0);
    check("t5_async_pc", mem_addr, 8'h00);
    check("t5_async_imm", imm, 8'h00);
    step();
    check("t5_held_c10", c10, 0);
    check("t5_held_pc", mem_addr, 8'h00);

    // Test 6: NOP sled to 0xFF, undefined opcode, pc wrap
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h90;
    reset_n = 1'b1;
    c10_seen = 0;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      step();
      if (c10) c10_seen++;
      if (mem_req && mem_addr == 8'hFF) found = 1'b1;
    end
    check("t6_reach_ff", found, 1);
    step();
    check("t6_dec_wrap", mem_addr, 8'h00);
    check("t6_dec_req", mem_req, 0);
    check("t6_dec_c10", c10, 0);
    step();
    check("t6_fetch0", {mem_req, mem_addr}, {1'b1, 8'h00});
    check("t6_no_c10", c10_seen + int'(c10), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
